// File: rtl/axi_mem_reader_pkg.sv
// rtl/axi_mem_reader_pkg.sv - shared AXI constants, FSM encoding and burst sizing for the memory reader
package axi_mem_reader_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_FIN
    } state_t;

    // Beats for the next burst: limited by words left, burst cap and the next 4 KB page edge.
    function automatic logic [31:0] burst_beats(input logic [31:0] rem,
                                                input logic [11:0] offs,
                                                input logic [31:0] max_beats);
        logic [31:0] beats;
        logic [31:0] to_page;
        to_page = (32'd4096 - {20'd0, offs}) >> 3;
        beats   = max_beats;
        if (to_page < beats) beats = to_page;
        if (rem < beats) beats = rem;
        return beats;
    endfunction

endpackage

// File: rtl/gen_fifo2.sv
// rtl/gen_fifo2.sv - two-entry valid/ready FIFO with registered storage
module gen_fifo2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign s_tready = (count != 2'd2);
    assign m_tvalid = (count != 2'd0);
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_mem_reader.sv
// rtl/axi_mem_reader.sv - AXI4 read master streaming a word region out with a running XOR signature
module axi_mem_reader
    import axi_mem_reader_pkg::*;
#(
    parameter int AW        = 64,
    parameter int DW        = 64,
    parameter int IDW       = 1,
    parameter int MAX_BEATS = 8
) (
    input  logic           CLK,
    input  logic           RSTn,
    input  logic           start,
    input  logic [AW-1:0]  base_addr,
    input  logic [31:0]    word_cnt,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [63:0]    signature,
    output logic [IDW-1:0] M_AXI_ARID,
    output logic [AW-1:0]  M_AXI_ARADDR,
    output logic [7:0]     M_AXI_ARLEN,
    output logic [2:0]     M_AXI_ARSIZE,
    output logic [1:0]     M_AXI_ARBURST,
    output logic           M_AXI_ARVALID,
    input  logic           M_AXI_ARREADY,
    input  logic [IDW-1:0] M_AXI_RID,
    input  logic [DW-1:0]  M_AXI_RDATA,
    input  logic [1:0]     M_AXI_RRESP,
    input  logic           M_AXI_RLAST,
    input  logic           M_AXI_RVALID,
    output logic           M_AXI_RREADY,
    output logic [63:0]    dump_data,
    output logic           dump_valid,
    input  logic           dump_ready
);
    state_t        state;
    logic [AW-1:0] addr;
    logic [31:0]   remaining;
    logic [AW-1:0] start_addr;
    logic          fifo_ready;
    logic          r_fire;
    logic          beat_err;
    logic          pop;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARSIZE  = AXI_SIZE_8B;
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_RREADY  = (state == ST_DATA) && fifo_ready;

    assign start_addr = base_addr & ~AW'(7);
    assign r_fire     = M_AXI_RVALID && M_AXI_RREADY;
    assign beat_err   = (M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RID != '0);
    assign pop        = dump_valid && dump_ready;

    gen_fifo2 #(.W(DW)) u_fifo (
        .clk      (CLK),
        .rst_n    (RSTn),
        .s_tdata  (M_AXI_RDATA),
        .s_tvalid (M_AXI_RVALID && (state == ST_DATA)),
        .s_tready (fifo_ready),
        .m_tdata  (dump_data),
        .m_tvalid (dump_valid),
        .m_tready (dump_ready)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= ST_IDLE;
            addr          <= '0;
            remaining     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            signature     <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARLEN   <= '0;
        end else begin
            done <= 1'b0;
            if (pop) signature <= signature ^ dump_data;
            if (r_fire && beat_err) err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        signature <= '0;
                        if (word_cnt != 32'd0) begin
                            addr          <= start_addr;
                            remaining     <= word_cnt;
                            M_AXI_ARADDR  <= start_addr;
                            M_AXI_ARLEN   <= 8'(burst_beats(word_cnt, start_addr[11:0], 32'(MAX_BEATS)) - 32'd1);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= ST_ADDR;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        addr          <= addr + ((AW'(M_AXI_ARLEN) + AW'(1)) << 3);
                        remaining     <= remaining - (32'(M_AXI_ARLEN) + 32'd1);
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // An error on the closing beat itself also stops further bursts.
                    if (r_fire && M_AXI_RLAST) begin
                        if (remaining != 32'd0 && !err && !beat_err) begin
                            M_AXI_ARADDR  <= addr;
                            M_AXI_ARLEN   <= 8'(burst_beats(remaining, addr[11:0], 32'(MAX_BEATS)) - 32'd1);
                            M_AXI_ARVALID <= 1'b1;
                            state         <= ST_ADDR;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    if (!dump_valid) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_mem_reader.md
Name: axi_mem_reader

Overview:
- AXI4 full read-only master that streams a contiguous 64-bit-word region of SoC memory out to a host-side sink.
- Counterpart of the SRAM image preload path: preload writes the program image in, this block reads results and signatures out.
- Sits beside riftChip on the AXI interconnect as a second master port.
- Keeps a running XOR signature so regression benches compare one word instead of dumping the whole region.

Parameters:
- AW, 64, address width.
- DW, 64, data width; fixed at 64 (ARSIZE=3).
- IDW, 1, AXI ID width.
- MAX_BEATS, 8, max beats per burst (1..16).

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- base_addr  in  AW  first word address; bits[2:0] ignored (treated 0)
- word_cnt  in  32  number of 64-bit words; 0 means immediate done
- busy  out  1  high from start-accept until done
- done  out  1  one-cycle pulse at end of transfer
- err  out  1  sticky; set on any RRESP!=OKAY or RID mismatch; cleared on next accepted start
- signature  out  64  XOR of all words emitted in the current run
- M_AXI_ARID  out  IDW  constant 0
- M_AXI_ARADDR  out  AW  burst start address
- M_AXI_ARLEN  out  8  beats-1
- M_AXI_ARSIZE  out  3  constant 3'b011
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
- M_AXI_ARVALID  out  1  address valid
- M_AXI_ARREADY  in  1  address ready
- M_AXI_RID  in  IDW  read ID
- M_AXI_RDATA  in  DW  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RLAST  in  1  last beat
- M_AXI_RVALID  in  1  read valid
- M_AXI_RREADY  out  1  read ready
- dump_data  out  64  streamed word
- dump_valid  out  1  stream valid
- dump_ready  in  1  stream ready

Behaviour:
- Reset values: all outputs 0 (busy, done, err, signature, ARVALID, RREADY, dump_valid, ARADDR, ARLEN). Reset mid-transfer aborts immediately: no further AR is issued and the stream is dropped.
- FSM states: IDLE, ADDR, DATA, FIN.
  - IDLE: on start with word_cnt!=0, latch addr/remaining, clear err and signature, set busy, go to ADDR.
  - IDLE: on start with word_cnt==0, go to FIN without any AXI activity.
  - ADDR: hold ARVALID=1 with ARADDR/ARLEN stable until ARREADY; then go to DATA.
  - DATA: when the beat carrying RLAST is accepted, go to ADDR if remaining>0 and err==0; otherwise go to FIN.
  - FIN: wait until the output buffer is empty, then pulse done for one cycle, drop busy, return to IDLE.
- Burst length per AR = min(remaining, MAX_BEATS, words to next 4 KB boundary) = min(rem, MAX_BEATS, (4096-addr[11:0])>>3). A burst never crosses 4 KB.
- After each AR handshake: addr += beats*8, remaining -= beats.
- One outstanding burst only; ARID is always 0.
- Output buffer: 2-entry FIFO between the R channel and the dump stream.
  - RREADY = (state==DATA) && FIFO not full.
  - An R beat is accepted on RVALID&&RREADY and pushed with RDATA.
  - Data latency: RDATA appears on dump_data 1 cycle after acceptance.
  - dump_valid = FIFO not empty. Pop on dump_valid&&dump_ready.
  - Simultaneous push and pop when full is not possible, because RREADY is low when full.
- Signature is updated on each pop: signature ^= dump_data.
- Error handling:
  - RRESP!=0 or RID!=0 sets err; the beat's data is still forwarded.
  - The current burst is drained to RLAST; no further bursts are issued; then FIN.
- A start pulse while busy is ignored.
- An RLAST arriving early or late is not checked; beat counting uses RLAST only.

Decomposition:
- Shared package/defines: AXI_BURST_INCR, AXI_RESP_OKAY, AXI_SIZE_8B constants and the FSM state encoding.
- Sub-module: gen_fifo2 (2-deep, DW wide, valid/ready), reusable elsewhere in the codebase.

Test Plan:
- base=0x8000_0000, word_cnt=20, always-ready slave and sink:
  - AR bursts have ARLEN 7, 7, 3 at addresses 0x8000_0000, 0x8000_0040, 0x8000_0080.
  - 20 words are streamed in order; signature equals the XOR of the model; err=0.
  - done pulses once.
- base=0x8000_0FE8, word_cnt=6:
  - First AR has ARLEN=2 (3 words up to the 4 KB boundary).
  - Second AR is at 0x8000_1000 with ARLEN=2.
- dump_ready toggles 1/0 every 3 cycles and the slave drives RVALID continuously:
  - RREADY deasserts whenever the FIFO holds 2 entries.
  - No word is lost or duplicated; order is preserved.
- RRESP=2'b10 on beat 3 of burst 1, word_cnt=16:
  - err rises and burst 1 completes (8 words out).
  - No second AR is issued; done pulses; err stays 1 until the next start.
- word_cnt=0 start:
  - No ARVALID; done pulses within 2 cycles; signature=0.
- RSTn asserted in DATA mid-burst:
  - All outputs return to 0 immediately.
  - A subsequent start with word_cnt=4 completes normally.
